gray_counter_ctl: RTL and testbench
===================================

Name: gray_counter_ctl

Overview:
- Parametrised up/down Gray-code counter with registered binary and Gray outputs, synchronous load, and selectable wrap or saturate.
- Successor to the fixed 4-bit binary_to_gray converter: same domain, now WIDTH-generic and stateful.
- Per-step event flags (terminal, wrap, toggled-bit mask) let downstream logic and benches check the single-bit-change property.
- Used as pointer/sequence source for clock-domain-crossing and position-encoder logic.

Parameters:
- WIDTH, 4, counter and code width in bits (legal range 2..16).
- WRAP, 1, 1 = modulo-2^WIDTH wrap-around; 0 = saturate at terminal value.
- RESET_VAL, 0, binary value loaded on reset (WIDTH bits).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_en  input  1  count enable; one step per cycle while high.
- i_up  input  1  direction: 1 = increment, 0 = decrement; sampled with i_en.
- i_load  input  1  synchronous load strobe; has priority over i_en.
- i_load_bin  input  WIDTH  binary value written on load.
- o_binary  output  WIDTH  registered binary count.
- o_gray  output  WIDTH  registered Gray code of o_binary, (b >> 1) ^ b.
- o_chg  output  WIDTH  registered mask: previous o_gray XOR new o_gray.
- o_tc  output  1  one-cycle pulse: a count step landed on the terminal value.
- o_wrap  output  1  one-cycle pulse: a count step wrapped around.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - o_binary = RESET_VAL; o_gray = Gray(RESET_VAL).
  - o_chg = 0, o_tc = 0, o_wrap = 0.
  - Reset asserted mid-count wins immediately; the count resumes from RESET_VAL on the first edge after deassertion.
- Priority each edge: i_load > i_en > hold.
- Load: o_binary <= i_load_bin and o_gray <= Gray(i_load_bin) on the same edge, latency 1.
  - o_chg = old gray ^ new gray (may be multi-bit or zero).
  - o_tc = 0, o_wrap = 0 on load cycles, even if the loaded value is terminal.
- Count step (i_en=1, i_load=0): next = o_binary + 1 (up) or - 1 (down), modulo 2^WIDTH.
  - o_binary and o_gray update together; o_gray never lags o_binary.
- Terminal value: all-ones when up, zero when down.
- WRAP=1:
  - up from all-ones -> 0 with o_wrap=1.
  - down from 0 -> all-ones with o_wrap=1.
  - o_chg is one-hot at the MSB in both cases.
- WRAP=0: a step at terminal holds the value; o_chg=0, o_tc=0, o_wrap=0 (no repeated pulses while saturated).
- o_tc = 1 for the cycle after any step whose new value equals the terminal for the current i_up.
  - This includes stepping onto zero while counting down.
  - o_tc and o_wrap never assert together.
- Every non-saturated count step produces an o_chg with exactly one bit set.
- Hold (i_en=0, i_load=0): values unchanged; o_chg, o_tc, o_wrap return to 0.
- Direction change between consecutive steps takes effect immediately, with no bubble cycle.
- Outputs are fully registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, WIDTH=4, RESET_VAL=0; release, hold i_en=1, i_up=1 for 16 cycles.
  - -> o_gray sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000.
  - -> o_chg one-hot on every step.
  - -> o_tc on the 1000 cycle; o_wrap on the 0000 cycle.
- Load i_load_bin=1011 with i_en=1 in the same cycle.
  - -> o_binary=1011, o_gray=1110, o_tc=0.
  - Next up step -> o_binary=1100, o_gray=1010, o_chg=0100.
- WRAP=0: count down from 0010 for 4 cycles.
  - -> values 0001, 0000 (o_tc=1), then 0000 held with o_chg=0000, o_tc=0, o_wrap=0.
- Toggle i_up every cycle from 0101.
  - -> binary 0110, 0101, 0110; o_gray alternates 0101/0111; o_chg=0010 each step.
- Assert i_rst_n low between clock edges while counting at 1001.
  - -> outputs go to Gray(RESET_VAL) before the next edge.
  - -> the first step after release gives binary RESET_VAL+1.
- WIDTH=8, WRAP=1, down from 00000000.
  - -> o_binary=11111111, o_gray=10000000, o_wrap=1, o_chg=10000000.

Source files
------------

// File: rtl/gray_counter_ctl_if.sv
// Control/status bundle for gray_counter_ctl: count/load strobes in, registered codes and event flags out.
interface gray_counter_ctl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             i_en;
    logic             i_up;
    logic             i_load;
    logic [WIDTH-1:0] i_load_bin;
    logic [WIDTH-1:0] o_binary;
    logic [WIDTH-1:0] o_gray;
    logic [WIDTH-1:0] o_chg;
    logic             o_tc;
    logic             o_wrap;

    modport master (
        output i_en, i_up, i_load, i_load_bin,
        input  o_binary, o_gray, o_chg, o_tc, o_wrap
    );

    modport slave (
        input  i_en, i_up, i_load, i_load_bin,
        output o_binary, o_gray, o_chg, o_tc, o_wrap
    );
endinterface

// File: rtl/gray_counter_ctl.sv
// Up/down Gray-code counter with synchronous load, wrap or saturate at the terminal value,
// and per-step event flags (terminal, wrap, toggled-bit mask). All outputs registered.
module gray_counter_ctl #(
    parameter int unsigned          WIDTH     = 4,
    parameter bit                   WRAP      = 1'b1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input logic              i_clk,
    input logic              i_rst_n,
    gray_counter_ctl_if.slave bus
);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] bin_q,  bin_nxt;
    logic [WIDTH-1:0] gray_q, gray_nxt;
    logic [WIDTH-1:0] chg_q,  chg_nxt;
    logic             tc_q,   tc_nxt;
    logic             wrap_q, wrap_nxt;
    logic [WIDTH-1:0] step;
    logic             at_term;

    // Next-state: load beats count beats hold; saturation suppresses the step and every flag.
    always_comb begin
        bin_nxt  = bin_q;
        tc_nxt   = 1'b0;
        wrap_nxt = 1'b0;
        step     = bus.i_up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
        at_term  = bus.i_up ? (bin_q == ALL_ONES) : (bin_q == '0);

        if (bus.i_load) begin
            bin_nxt = bus.i_load_bin;
        end else if (bus.i_en) begin
            if (!(at_term && !WRAP)) begin
                bin_nxt  = step;
                wrap_nxt = at_term;
                tc_nxt   = bus.i_up ? (step == ALL_ONES) : (step == '0);
            end
        end

        gray_nxt = to_gray(bin_nxt);
        chg_nxt  = gray_nxt ^ gray_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bin_q  <= RESET_VAL;
            gray_q <= to_gray(RESET_VAL);
            chg_q  <= '0;
            tc_q   <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_nxt;
            gray_q <= gray_nxt;
            chg_q  <= chg_nxt;
            tc_q   <= tc_nxt;
            wrap_q <= wrap_nxt;
        end
    end

    assign bus.o_binary = bin_q;
    assign bus.o_gray   = gray_q;
    assign bus.o_chg    = chg_q;
    assign bus.o_tc     = tc_q;
    assign bus.o_wrap   = wrap_q;
endmodule

// File: tb/tb_gray_counter_ctl.sv
// Bench for gray_counter_ctl: three configurations (4-bit wrap, 4-bit saturate, 8-bit wrap)
// checked against an arithmetic reference model plus directed known-answer points.
module tb_gray_counter_ctl;
    logic clk = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gray_counter_ctl_if #(.WIDTH(4)) bus_a ();
    gray_counter_ctl_if #(.WIDTH(4)) bus_b ();
    gray_counter_ctl_if #(.WIDTH(8)) bus_c ();

    gray_counter_ctl #(.WIDTH(4), .WRAP(1'b1), .RESET_VAL(4'd0)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n_a), .bus(bus_a));
    gray_counter_ctl #(.WIDTH(4), .WRAP(1'b0), .RESET_VAL(4'd3)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));
    gray_counter_ctl #(.WIDTH(8), .WRAP(1'b1), .RESET_VAL(8'd0)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_c));

    int checks = 0;
    int errors = 0;
    int cur[3];
    int widths[3] = '{4, 4, 8};
    bit wraps[3]  = '{1'b1, 1'b0, 1'b1};

    function automatic int gry(input int b);
        return b ^ (b >> 1);
    endfunction

    // Reference: step by +/-1 in plain integers; leaving [0, 2^w-1] is a wrap (or a saturated hold).
    function automatic void model(input int w, input bit wrp, input int c, input bit en,
                                  input bit up, input bit load, input int lb,
                                  output int nb, output int chg, output bit tc, output bit wf);
        int mx;
        int raw;
        mx  = (1 << w) - 1;
        nb  = c;
        tc  = 1'b0;
        wf  = 1'b0;
        raw = up ? c + 1 : c - 1;
        if (load) begin
            nb = lb & mx;
        end else if (en) begin
            if (raw < 0 || raw > mx) begin
                if (wrp) begin
                    nb = raw & mx;
                    wf = 1'b1;
                end
            end else begin
                nb = raw;
                tc = up ? (raw == mx) : (raw == 0);
            end
        end
        chg = gry(nb) ^ gry(c);
    endfunction

    task automatic idle_all();
        bus_a.i_en = 1'b0; bus_a.i_up = 1'b0; bus_a.i_load = 1'b0; bus_a.i_load_bin = '0;
        bus_b.i_en = 1'b0; bus_b.i_up = 1'b0; bus_b.i_load = 1'b0; bus_b.i_load_bin = '0;
        bus_c.i_en = 1'b0; bus_c.i_up = 1'b0; bus_c.i_load = 1'b0; bus_c.i_load_bin = '0;
    endtask

    // One clock on instance inst (others idle), compared in full against the model.
    task automatic step(input int inst, input bit en, input bit up, input bit load,
                        input int lb, input string tag);
        int nb, chg;
        bit tc, wf;
        logic [7:0] g_bin, g_gray, g_chg;
        logic       g_tc, g_wrap;
        @(negedge clk);
        idle_all();
        case (inst)
            0: begin bus_a.i_en = en; bus_a.i_up = up; bus_a.i_load = load; bus_a.i_load_bin = 4'(lb); end
            1: begin bus_b.i_en = en; bus_b.i_up = up; bus_b.i_load = load; bus_b.i_load_bin = 4'(lb); end
            default: begin bus_c.i_en = en; bus_c.i_up = up; bus_c.i_load = load; bus_c.i_load_bin = 8'(lb); end
        endcase
        model(widths[inst], wraps[inst], cur[inst], en, up, load, lb, nb, chg, tc, wf);
        @(posedge clk);
        #1;
        case (inst)
            0: begin g_bin = 8'(bus_a.o_binary); g_gray = 8'(bus_a.o_gray); g_chg = 8'(bus_a.o_chg);
                     g_tc = bus_a.o_tc; g_wrap = bus_a.o_wrap; end
            1: begin g_bin = 8'(bus_b.o_binary); g_gray = 8'(bus_b.o_gray); g_chg = 8'(bus_b.o_chg);
                     g_tc = bus_b.o_tc; g_wrap = bus_b.o_wrap; end
            default: begin g_bin = bus_c.o_binary; g_gray = bus_c.o_gray; g_chg = bus_c.o_chg;
                     g_tc = bus_c.o_tc; g_wrap = bus_c.o_wrap; end
        endcase
        checks++;
        if ({g_bin, g_gray, g_chg, g_tc, g_wrap} !== {8'(nb), 8'(gry(nb)), 8'(chg), tc, wf}) begin
            errors++;
            $display("FAIL %s inst%0d: got bin=%h gray=%h chg=%h tc=%b wrap=%b, expected bin=%h gray=%h chg=%h tc=%b wrap=%b",
                     tag, inst, g_bin, g_gray, g_chg, g_tc, g_wrap,
                     8'(nb), 8'(gry(nb)), 8'(chg), tc, wf);
        end
        cur[inst] = nb;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus_a.o_binary, bus_a.o_gray, bus_a.o_chg, bus_a.o_tc, bus_a.o_wrap} !== 14'b0) begin
            errors++;
            $display("FAIL reset_a: got bin=%h gray=%h chg=%h, expected all zero",
                     bus_a.o_binary, bus_a.o_gray, bus_a.o_chg);
        end
        checks++;
        if ({bus_b.o_binary, bus_b.o_gray, bus_b.o_chg, bus_b.o_tc, bus_b.o_wrap} !== {4'd3, 4'd2, 4'd0, 2'b00}) begin
            errors++;
            $display("FAIL reset_b: got bin=%h gray=%h chg=%h, expected bin=3 gray=2 chg=0",
                     bus_b.o_binary, bus_b.o_gray, bus_b.o_chg);
        end
        checks++;
        if ({bus_c.o_binary, bus_c.o_gray, bus_c.o_tc, bus_c.o_wrap} !== 18'b0) begin
            errors++;
            $display("FAIL reset_c: got bin=%h gray=%h, expected 0", bus_c.o_binary, bus_c.o_gray);
        end
        cur[0] = 0; cur[1] = 3; cur[2] = 0;
    endtask

    task automatic test_count_up_wrap();
        logic [3:0] seq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        for (int k = 1; k <= 16; k++) begin
            step(0, 1'b1, 1'b1, 1'b0, 0, "count_up");
            checks++;
            if (bus_a.o_gray !== seq[k % 16] || $countones(bus_a.o_chg) != 1) begin
                errors++;
                $display("FAIL gray_seq step%0d: got gray=%b chg=%b, expected gray=%b with one-hot chg",
                         k, bus_a.o_gray, bus_a.o_chg, seq[k % 16]);
            end
            checks++;
            if (bus_a.o_tc !== (k == 15) || bus_a.o_wrap !== (k == 16)) begin
                errors++;
                $display("FAIL up_flags step%0d: got tc=%b wrap=%b, expected tc=%b wrap=%b",
                         k, bus_a.o_tc, bus_a.o_wrap, k == 15, k == 16);
            end
        end
    endtask

    task automatic test_load();
        step(0, 1'b1, 1'b1, 1'b1, 11, "load");
        checks++;
        if ({bus_a.o_binary, bus_a.o_gray, bus_a.o_tc} !== {4'b1011, 4'b1110, 1'b0}) begin
            errors++;
            $display("FAIL load_1011: got bin=%b gray=%b tc=%b, expected 1011 1110 0",
                     bus_a.o_binary, bus_a.o_gray, bus_a.o_tc);
        end
        step(0, 1'b1, 1'b1, 1'b0, 0, "after_load");
        checks++;
        if ({bus_a.o_binary, bus_a.o_gray, bus_a.o_chg} !== {4'b1100, 4'b1010, 4'b0100}) begin
            errors++;
            $display("FAIL after_load: got bin=%b gray=%b chg=%b, expected 1100 1010 0100",
                     bus_a.o_binary, bus_a.o_gray, bus_a.o_chg);
        end
        step(0, 1'b0, 1'b1, 1'b1, 15, "load_terminal");
        step(0, 1'b0, 1'b0, 1'b0, 0, "hold");
    endtask

    task automatic test_saturate();
        logic [3:0] exp_bin [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
        step(1, 1'b0, 1'b0, 1'b1, 2, "sat_load");
        for (int k = 0; k < 4; k++) begin
            step(1, 1'b1, 1'b0, 1'b0, 0, "sat_down");
            checks++;
            if (bus_b.o_binary !== exp_bin[k] || bus_b.o_tc !== (k == 1) || bus_b.o_wrap !== 1'b0
                || (k >= 2 && bus_b.o_chg !== 4'b0000)) begin
                errors++;
                $display("FAIL sat_down k%0d: got bin=%b tc=%b wrap=%b chg=%b, expected bin=%b tc=%b wrap=0",
                         k, bus_b.o_binary, bus_b.o_tc, bus_b.o_wrap, bus_b.o_chg, exp_bin[k], k == 1);
            end
        end
        step(1, 1'b0, 1'b0, 1'b1, 14, "sat_load_hi");
        for (int k = 0; k < 3; k++) step(1, 1'b1, 1'b1, 1'b0, 0, "sat_up");
    endtask

    task automatic test_direction_toggle();
        step(0, 1'b0, 1'b0, 1'b1, 5, "dir_load");
        for (int k = 0; k < 3; k++) begin
            step(0, 1'b1, (k % 2) == 0, 1'b0, 0, "dir_toggle");
            checks++;
            if (bus_a.o_binary !== ((k % 2) == 0 ? 4'b0110 : 4'b0101) || bus_a.o_chg !== 4'b0010
                || bus_a.o_gray !== ((k % 2) == 0 ? 4'b0101 : 4'b0111)) begin
                errors++;
                $display("FAIL dir_toggle k%0d: got bin=%b gray=%b chg=%b", k,
                         bus_a.o_binary, bus_a.o_gray, bus_a.o_chg);
            end
        end
    endtask

    task automatic test_async_reset();
        step(0, 1'b0, 1'b0, 1'b1, 8, "ar_load");
        step(0, 1'b1, 1'b1, 1'b0, 0, "ar_count");
        #2;
        idle_all();
        rst_n_a = 1'b0;
        #1;
        checks++;
        if ({bus_a.o_binary, bus_a.o_gray, bus_a.o_chg, bus_a.o_tc, bus_a.o_wrap} !== 14'b0) begin
            errors++;
            $display("FAIL async_reset: got bin=%b gray=%b chg=%b tc=%b wrap=%b, expected zeros",
                     bus_a.o_binary, bus_a.o_gray, bus_a.o_chg, bus_a.o_tc, bus_a.o_wrap);
        end
        @(negedge clk);
        rst_n_a = 1'b1;
        cur[0] = 0;
        step(0, 1'b1, 1'b1, 1'b0, 0, "post_reset");
        checks++;
        if (bus_a.o_binary !== 4'd1) begin
            errors++;
            $display("FAIL post_reset: got bin=%b, expected 0001", bus_a.o_binary);
        end
    endtask

    task automatic test_width8_wrap();
        step(2, 1'b1, 1'b0, 1'b0, 0, "w8_down_wrap");
        checks++;
        if ({bus_c.o_binary, bus_c.o_gray, bus_c.o_chg, bus_c.o_wrap, bus_c.o_tc}
            !== {8'hFF, 8'h80, 8'h80, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL w8_wrap: got bin=%h gray=%h chg=%h wrap=%b tc=%b, expected ff 80 80 1 0",
                     bus_c.o_binary, bus_c.o_gray, bus_c.o_chg, bus_c.o_wrap, bus_c.o_tc);
        end
        step(2, 1'b1, 1'b1, 1'b0, 0, "w8_up_wrap");
    endtask

    task automatic test_random();
        for (int i = 0; i < 900; i++) begin
            int inst;
            inst = i % 3;
            step(inst, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 11) == 0, int'($urandom_range(0, 255)), "random");
        end
    endtask

    initial begin
        idle_all();
        repeat (2) @(negedge clk);
        rst_n_a = 1'b1;
        rst_n   = 1'b1;
        #1;
        test_reset();
        test_count_up_wrap();
        test_load();
        test_saturate();
        test_direction_toggle();
        test_async_reset();
        test_width8_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
